// File: rtl/i2s_rx_if.sv
// Output bus of the I2S receiver: the held stereo frame with its valid/ready handshake,
// overrun flag and its clear, and the lock indication.
interface i2s_rx_if #(
    parameter int unsigned DATA_WIDTH = 24
) ();
    logic [DATA_WIDTH-1:0] sample_l;
    logic [DATA_WIDTH-1:0] sample_r;
    logic                  valid;
    logic                  ready;
    logic                  overrun;
    logic                  clear_i;
    logic                  locked;

    modport master (
        output sample_l, sample_r, valid, overrun, locked,
        input  ready, clear_i
    );

    modport slave (
        input  sample_l, sample_r, valid, overrun, locked,
        output ready, clear_i
    );
endinterface

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples BCLK/LRCLK/SDATA in the clk domain, rebuilds left-justified
// PCM words and presents complete stereo frames through a holding register.
module i2s_rx #(
    parameter int unsigned DATA_WIDTH  = 24,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      bclk_i,
    input  logic      lrclk_i,
    input  logic      sdata_i,
    i2s_rx_if.master  out_if
);
    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [0:0] {StUnlocked, StLocked} lock_e;

    logic [SYNC_STAGES-1:0] bclk_sync_q, lrclk_sync_q, sdata_sync_q;
    logic                   bclk_prev_q, lr_prev_q, cur_ch_q, left_ok_q;
    logic [DATA_WIDTH-1:0]  shreg_q, left_pend_q, sample_l_q, sample_r_q;
    logic [CntW-1:0]        bit_cnt_q;
    logic                   valid_q, overrun_q;
    lock_e                  state_q;

    logic                   bclk_s, lr_s, sd_s, rise;
    logic [DATA_WIDTH-1:0]  shreg_shift, word;
    logic [CntW-1:0]        cnt_shift;

    always_comb begin
        bclk_s      = bclk_sync_q[SYNC_STAGES-1];
        lr_s        = lrclk_sync_q[SYNC_STAGES-1];
        sd_s        = sdata_sync_q[SYNC_STAGES-1];
        rise        = bclk_s & ~bclk_prev_q;
        shreg_shift = shreg_q;
        cnt_shift   = bit_cnt_q;
        // Bits past DATA_WIDTH are dropped; the counter saturates.
        if (bit_cnt_q < CntW'(DATA_WIDTH)) begin
            shreg_shift = {shreg_q[DATA_WIDTH-2:0], sd_s};
            cnt_shift   = bit_cnt_q + CntW'(1);
        end
        // Left-justify short slots by padding zeros below the received bits.
        word = shreg_shift << (CntW'(DATA_WIDTH) - cnt_shift);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bclk_sync_q  <= '0;
            lrclk_sync_q <= '0;
            sdata_sync_q <= '0;
            bclk_prev_q  <= 1'b0;
            lr_prev_q    <= 1'b0;
            cur_ch_q     <= 1'b0;
            left_ok_q    <= 1'b0;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            left_pend_q  <= '0;
            sample_l_q   <= '0;
            sample_r_q   <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            state_q      <= StUnlocked;
        end else begin
            bclk_sync_q  <= {bclk_sync_q[SYNC_STAGES-2:0], bclk_i};
            lrclk_sync_q <= {lrclk_sync_q[SYNC_STAGES-2:0], lrclk_i};
            sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], sdata_i};
            bclk_prev_q  <= bclk_s;

            if (out_if.clear_i) overrun_q <= 1'b0;
            if (valid_q && out_if.ready) valid_q <= 1'b0;

            if (rise) begin
                shreg_q   <= shreg_shift;
                bit_cnt_q <= cnt_shift;
                lr_prev_q <= lr_s;
                if (lr_s != lr_prev_q) begin
                    shreg_q   <= '0;
                    bit_cnt_q <= '0;
                    cur_ch_q  <= lr_s;
                    unique case (state_q)
                        StUnlocked: state_q <= StLocked;
                        StLocked: begin
                            if (!cur_ch_q) begin
                                left_pend_q <= word;
                                left_ok_q   <= 1'b1;
                            end else if (left_ok_q) begin
                                // Later assignments win over the clear/transfer above.
                                left_ok_q  <= 1'b0;
                                sample_l_q <= left_pend_q;
                                sample_r_q <= word;
                                valid_q    <= 1'b1;
                                if (valid_q && !out_if.ready) overrun_q <= 1'b1;
                            end
                        end
                        default: state_q <= StUnlocked;
                    endcase
                end
            end
        end
    end

    assign out_if.sample_l = sample_l_q;
    assign out_if.sample_r = sample_r_q;
    assign out_if.valid    = valid_q;
    assign out_if.overrun  = overrun_q;
    assign out_if.locked   = (state_q == StLocked);
endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: directed I2S streams, expected frames queued by the stimulus and
// checked by an independent monitor on every valid/ready transfer.
module tb_i2s_rx;
    localparam int unsigned DW = 24;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic bclk  = 1'b0;
    logic lrclk = 1'b0;
    logic sdata = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [2*DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    i2s_rx_if #(.DATA_WIDTH(DW)) bus ();

    i2s_rx #(
        .DATA_WIDTH  (DW),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bclk_i  (bclk),
        .lrclk_i (lrclk),
        .sdata_i (sdata),
        .out_if  (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bit period of 8 clk; optional one-cycle ready pulse on the load edge.
    task automatic send_bit(input logic lr, input logic d, input bit pulse);
        bclk  = 1'b0;
        lrclk = lr;
        sdata = d;
        tick(4);
        bclk = 1'b1;
        if (pulse) begin
            tick(2);
            bus.ready = 1'b1;
            tick(1);
            bus.ready = 1'b0;
            tick(1);
        end else begin
            tick(4);
        end
    endtask

    // Standard I2S: LRCLK flips on the slot's LSB, one bit ahead of the next MSB.
    task automatic send_slot(input logic lr, input logic [31:0] w, input int len,
                             input bit pulse);
        for (int k = 0; k < len; k++)
            send_bit((k == len - 1) ? ~lr : lr, w[len-1-k], pulse && (k == len - 1));
    endtask

    task automatic send_frame24(input logic [DW-1:0] l, input logic [DW-1:0] r,
                                input bit pulse);
        send_slot(1'b0, {l, 8'h00}, 32, 1'b0);
        send_slot(1'b1, {r, 8'h00}, 32, pulse);
    endtask

    always @(negedge clk) begin : monitor
        logic [2*DW-1:0] e;
        if (!rst && bus.valid && bus.ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL frame_unexpected: got %h/%h expected none",
                         bus.sample_l, bus.sample_r);
            end else begin
                e = exp_q.pop_front();
                check("frame_l", 32'(bus.sample_l), 32'(e[2*DW-1:DW]));
                check("frame_r", 32'(bus.sample_r), 32'(e[DW-1:0]));
            end
        end
    end

    initial begin
        bus.ready   = 1'b1;
        bus.clear_i = 1'b0;
        tick(3);
        check("rst_sample_l", 32'(bus.sample_l), 32'h0);
        check("rst_sample_r", 32'(bus.sample_r), 32'h0);
        check("rst_valid", 32'(bus.valid), 32'h0);
        check("rst_overrun", 32'(bus.overrun), 32'h0);
        check("rst_locked", 32'(bus.locked), 32'h0);
        rst = 1'b0;
        tick(2);
        check("unlocked_idle", 32'(bus.locked), 32'h0);

        // Lock on a partial right slot, then two full frames.
        send_slot(1'b1, 32'h0000_02A5, 10, 1'b0);
        check("locked_after_edge", 32'(bus.locked), 32'h1);
        exp_q.push_back({24'h123456, 24'hABCDEF});
        exp_q.push_back({24'h123456, 24'hABCDEF});
        send_frame24(24'h123456, 24'hABCDEF, 1'b0);
        send_frame24(24'h123456, 24'hABCDEF, 1'b0);
        tick(4);
        check("no_overrun_streaming", 32'(bus.overrun), 32'h0);

        // Back-pressure across two frames.
        bus.ready = 1'b0;
        send_frame24(24'h000001, 24'h000002, 1'b0);
        check("bp_first_no_overrun", 32'(bus.overrun), 32'h0);
        send_frame24(24'h000003, 24'h000004, 1'b0);
        check("bp_overrun", 32'(bus.overrun), 32'h1);
        check("bp_valid", 32'(bus.valid), 32'h1);
        check("bp_held_l", 32'(bus.sample_l), 32'h000003);
        check("bp_held_r", 32'(bus.sample_r), 32'h000004);
        exp_q.push_back({24'h000003, 24'h000004});
        bus.ready = 1'b1;
        tick(3);
        check("bp_valid_dropped", 32'(bus.valid), 32'h0);
        check("bp_overrun_sticky", 32'(bus.overrun), 32'h1);
        bus.clear_i = 1'b1;
        tick(1);
        bus.clear_i = 1'b0;
        check("bp_overrun_cleared", 32'(bus.overrun), 32'h0);

        // Ready only in the load cycle of the following frame.
        bus.ready = 1'b0;
        exp_q.push_back({24'h000005, 24'h000006});
        send_frame24(24'h000005, 24'h000006, 1'b0);
        send_frame24(24'h000007, 24'h000008, 1'b1);
        check("sim_valid", 32'(bus.valid), 32'h1);
        check("sim_overrun", 32'(bus.overrun), 32'h0);
        check("sim_new_l", 32'(bus.sample_l), 32'h000007);
        check("sim_new_r", 32'(bus.sample_r), 32'h000008);
        exp_q.push_back({24'h000007, 24'h000008});
        bus.ready = 1'b1;
        tick(3);

        // Short 16-bit slots are left-justified.
        exp_q.push_back({24'hBEEF00, 24'h123400});
        send_slot(1'b0, 32'h0000_BEEF, 16, 1'b0);
        send_slot(1'b1, 32'h0000_1234, 16, 1'b0);
        tick(3);

        // Long 32-bit slots keep only the first 24 bits.
        exp_q.push_back({24'h7FFFFF, 24'h800000});
        send_slot(1'b0, 32'h7FFF_FFFF, 32, 1'b0);
        send_slot(1'b1, 32'h8000_0001, 32, 1'b0);
        tick(3);

        // Reset partway through a right slot.
        send_slot(1'b0, 32'h1111_1100, 32, 1'b0);
        for (int k = 0; k < 16; k++) send_bit(1'b1, 1'b1, 1'b0);
        #3;
        rst  = 1'b1;
        bclk = 1'b0;
        #1;
        check("arst_sample_l", 32'(bus.sample_l), 32'h0);
        check("arst_sample_r", 32'(bus.sample_r), 32'h0);
        check("arst_locked", 32'(bus.locked), 32'h0);
        check("arst_valid", 32'(bus.valid), 32'h0);
        tick(3);
        rst = 1'b0;
        send_slot(1'b1, 32'h0000_FFFF, 16, 1'b0);
        check("relock", 32'(bus.locked), 32'h1);
        exp_q.push_back({24'h222222, 24'h333333});
        send_frame24(24'h222222, 24'h333333, 1'b0);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL frames_outstanding: got %0d pending expected 0", exp_q.size());
        end
        tick(20);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- Receive side of the codec serial audio link: deserialises the ADC stream (ac_adc_sdata) framed by the BCLK/LRCLK pair that the transmit controller drives to the codec.
- Oversamples BCLK, LRCLK and SDATA in the system clock domain and rebuilds signed left/right PCM words.
- Presents each stereo frame through a valid/ready holding register with overrun detection, for use by the mixer, the display scope path and the mic monitor.
- Sits beside the transmit controller in top; shares clk and its BCLK/LRCLK outputs.

Parameters:
- DATA_WIDTH, 24, bits captured per channel, MSB first; slot bits beyond this are ignored.
- SYNC_STAGES, 2, flip-flop stages on each serial input (minimum 2).

Ports:
- clk  in  1  system clock (100 MHz); sole clock.
- rst  in  1  reset, asynchronous and active-high.
- bclk_i  in  1  serial bit clock from the link; data is valid on its rising edge.
- lrclk_i  in  1  word select; 0 = left slot, 1 = right slot.
- sdata_i  in  1  serial data from the codec ADC.
- sample_l  out  DATA_WIDTH  left word of the held frame.
- sample_r  out  DATA_WIDTH  right word of the held frame.
- valid  out  1  held frame available.
- ready  in  1  consumer accepts the held frame this cycle.
- overrun  out  1  sticky; a frame arrived while the previous one was unread.
- clear_i  in  1  synchronous clear of overrun.
- locked  out  1  frame alignment acquired.

Behaviour:
- Reset values: sample_l = 0, sample_r = 0, valid = 0, overrun = 0, locked = 0. Internal state also resets: shift register, bit counter, channel, and all synchroniser stages (to 0).
- Synchronisers:
  - bclk_i, lrclk_i and sdata_i each pass through SYNC_STAGES flops.
  - Because the stages are identical, the three signals stay mutually aligned.
- Edge detection:
  - A BCLK rise is a cycle where synced bclk = 1 and the previous synced bclk = 0.
  - All actions below occur only in rise cycles.
  - Latency from a pin edge to its rise cycle = SYNC_STAGES + 1 clk.
- Per rise, in this order:
  1. If bit_cnt < DATA_WIDTH: shift the synced sdata into the LSB of shreg and increment bit_cnt. Otherwise the bit is dropped and bit_cnt saturates.
  2. If the synced lrclk differs from lr_prev (a transition), commit:
     - word = shreg << (DATA_WIDTH - bit_cnt), i.e. left-justified with zero-padded LSBs for short slots;
     - the word goes to the channel in cur_ch;
     - then cur_ch <= synced lrclk, shreg <= 0, bit_cnt <= 0.
  3. lr_prev <= synced lrclk.
- Framing consequence: with standard I2S timing, the bit on the transition rise is the LSB of the outgoing slot, and the MSB of the new slot is captured on the following rise.
- Lock states:
  - UNLOCKED: commits are discarded. The first transition moves to LOCKED, and locked goes high in the cycle after that rise.
  - LOCKED: a left commit stores into left_pend and sets left_ok. A right commit with left_ok set completes a frame and clears left_ok. A right commit without left_ok is discarded.
- Frame completion, in the cycle after the completing rise:
  - sample_l <= left_pend, sample_r <= right word, valid <= 1.
- Handshake:
  - Transfer occurs on any clk cycle with valid && ready; valid drops the next cycle unless a new frame loads in that same cycle.
  - A load in the same cycle as a transfer: the old frame is taken, the new frame is loaded, valid stays 1, no overrun.
  - A load while valid && !ready: the held frame is overwritten with the newest one, valid stays 1, overrun <= 1.
  - overrun clears only through clear_i. If clear_i and a new overrun occur in the same cycle, overrun stays set.
- Glitch tolerance: a BCLK high or low phase shorter than 1 clk is not guaranteed to be seen; a BCLK period of at least 4 clk is required.
- Mid-operation reset: all state returns to its reset values immediately, regardless of clk. After release the block re-acquires lock; the first output frame is the first complete left+right pair whose left slot began after lock.

Test Plan:
- Lock and first frame:
  - Stimulus: bclk = clk/8, 32-bit slots, DATA_WIDTH = 24, left = 0x123456, right = 0xABCDEF, repeated.
  - Required: locked rises after the first LRCLK edge; the first valid frame gives sample_l = 0x123456, sample_r = 0xABCDEF; the partial frame before lock is never output.
- Back-pressure:
  - Stimulus: ready held 0 across two frames (0x000001/0x000002, then 0x000003/0x000004).
  - Required: overrun = 1, held frame = 0x000003/0x000004, valid stays 1; clear_i pulse brings overrun to 0.
- Simultaneous ready and load:
  - Stimulus: ready = 1 exactly in the load cycle of the next frame.
  - Required: valid stays 1, overrun stays 0, and the new words appear.
- Short slots:
  - Stimulus: 16-bit slots, left bits 0xBEEF.
  - Required: sample_l = 0xBEEF00.
- Long slots:
  - Stimulus: 32-bit slots, left bits 0x7FFFFF followed by 8 ones.
  - Required: sample_l = 0x7FFFFF (extra bits dropped).
- Reset mid-slot:
  - Stimulus: assert rst for 3 clk partway through a right slot.
  - Required: all outputs go to 0 asynchronously; the next valid frame is fully correct; no mixed-frame data.
